// File: rtl/axil_single_master_pkg.sv
// Shared types and constants for the single-outstanding AXI-lite master.
// Holds the controller state encoding, the AXI response codes and the
// fixed protection value driven on AWPROT/ARPROT.
package axil_single_master_pkg;

    // Controller states; one transaction is in flight at any time
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WRESP  = 3'd2,
        READ   = 3'd3,
        RRESP  = 3'd4,
        RETURN = 3'd5
    } state_t;

    // AXI xRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Anything other than OKAY is reported upstream as an error
    function automatic logic respIsError(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axil_single_master.sv
// axil_single_master
// Bridges a simple valid/ready command/response port onto an AXI-lite
// master interface, keeping at most one AXI transaction outstanding.
// The AW and W channels are tracked by independent valid registers so
// the two handshakes may complete in either order or together.
//
// Optional build macro: AXIL_SINGLE_MASTER_LOWPOWER_EN
//   When defined, AXI payloads and the response payload are forced to
//   zero whenever their VALID is low, reducing toggling on idle buses.
//   When undefined, payloads hold their last value. Handshake timing is
//   the same in both builds.
module axil_single_master
    import axil_single_master_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,

    // Command port
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_we,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] i_cmd_strb,

    // Response port
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]   o_rsp_data,
    output logic                          o_rsp_err,

    // AXI-lite write address channel
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,

    // AXI-lite write data channel
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,

    // AXI-lite write response channel
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    input  logic [1:0]                    M_AXI_BRESP,

    // AXI-lite read address channel
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,

    // AXI-lite read data channel
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    state_t                        state_q,   state_d;
    logic                          awValid_q, awValid_d;
    logic                          wValid_q,  wValid_d;
    logic                          arValid_q, arValid_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   awAddr_q,  awAddr_d;
    logic [C_AXI_DATA_WIDTH-1:0]   wData_q,   wData_d;
    logic [STRB_W-1:0]             wStrb_q,   wStrb_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   arAddr_q,  arAddr_d;
    logic [C_AXI_DATA_WIDTH-1:0]   rspData_q, rspData_d;
    logic                          rspErr_q,  rspErr_d;

    // State and payload registers; reset abandons any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            arValid_q <= 1'b0;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            arAddr_q  <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awValid_q <= awValid_d;
            wValid_q  <= wValid_d;
            arValid_q <= arValid_d;
            awAddr_q  <= awAddr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            arAddr_q  <= arAddr_d;
            rspData_q <= rspData_d;
            rspErr_q  <= rspErr_d;
        end
    end

    // Next-state logic: accept a command, run its AXI handshakes, hand the result back
    always_comb begin
        state_d   = state_q;
        awValid_d = awValid_q;
        wValid_d  = wValid_q;
        arValid_d = arValid_q;
        awAddr_d  = awAddr_q;
        wData_d   = wData_q;
        wStrb_d   = wStrb_q;
        arAddr_d  = arAddr_q;
        rspData_d = rspData_q;
        rspErr_d  = rspErr_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_we) begin
                        awAddr_d  = i_cmd_addr;
                        wData_d   = i_cmd_data;
                        wStrb_d   = i_cmd_strb;
                        awValid_d = 1'b1;
                        wValid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arAddr_d  = i_cmd_addr;
                        arValid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end

            WRITE: begin
                if (awValid_q && M_AXI_AWREADY) begin
                    awValid_d = 1'b0;
                end
                if (wValid_q && M_AXI_WREADY) begin
                    wValid_d = 1'b0;
                end
                if (!awValid_d && !wValid_d) begin
                    state_d = WRESP;
                end
            end

            WRESP: begin
                if (M_AXI_BVALID) begin
                    rspData_d = '0;
                    rspErr_d  = respIsError(M_AXI_BRESP);
                    state_d   = RETURN;
                end
            end

            READ: begin
                if (M_AXI_ARREADY) begin
                    arValid_d = 1'b0;
                    state_d   = RRESP;
                end
            end

            RRESP: begin
                if (M_AXI_RVALID) begin
                    rspData_d = M_AXI_RDATA;
                    rspErr_d  = respIsError(M_AXI_RRESP);
                    state_d   = RETURN;
                end
            end

            RETURN: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                awValid_d = 1'b0;
                wValid_d  = 1'b0;
                arValid_d = 1'b0;
            end
        endcase
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_rsp_valid   = (state_q == RETURN);
    assign M_AXI_BREADY  = (state_q == WRESP);
    assign M_AXI_RREADY  = (state_q == RRESP);

    assign M_AXI_AWVALID = awValid_q;
    assign M_AXI_WVALID  = wValid_q;
    assign M_AXI_ARVALID = arValid_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_ARPROT  = PROT_DEFAULT;

`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
    assign M_AXI_AWADDR  = awValid_q ? awAddr_q : '0;
    assign M_AXI_WDATA   = wValid_q  ? wData_q  : '0;
    assign M_AXI_WSTRB   = wValid_q  ? wStrb_q  : '0;
    assign M_AXI_ARADDR  = arValid_q ? arAddr_q : '0;
    assign o_rsp_data    = o_rsp_valid ? rspData_q : '0;
    assign o_rsp_err     = o_rsp_valid & rspErr_q;
`else
    assign M_AXI_AWADDR  = awAddr_q;
    assign M_AXI_WDATA   = wData_q;
    assign M_AXI_WSTRB   = wStrb_q;
    assign M_AXI_ARADDR  = arAddr_q;
    assign o_rsp_data    = rspData_q;
    assign o_rsp_err     = rspErr_q;
`endif

endmodule

// File: tb/tb_axil_single_master.sv
// Testbench for axil_single_master.
// A reactive AXI-lite slave with per-channel ready delays answers the
// master; every issued command pushes its expected response onto a
// scoreboard queue that is popped when the response port handshakes.
// Event cycles are recorded relative to command acceptance so latency
// and ordering can be compared against fixed expectations.
// Honors AXIL_SINGLE_MASTER_LOWPOWER_EN for idle-payload expectations.
module tb_axil_single_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_we = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [DW-1:0] i_cmd_data = '0;
    logic [3:0]    i_cmd_strb = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic          M_AXI_AWVALID, M_AXI_AWREADY = 1'b0;
    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_WVALID, M_AXI_WREADY = 1'b0;
    logic [DW-1:0] M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_BVALID = 1'b0, M_AXI_BREADY;
    logic [1:0]    M_AXI_BRESP = 2'b00;
    logic          M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_RVALID = 1'b0, M_AXI_RREADY;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;

    axil_single_master #(
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Slave configuration
    int         awDelay = 0, wDelay = 0, arDelay = 0, rspHold = 0;
    logic [1:0] bResp = OKAY, rResp = OKAY;
    logic [DW-1:0] rData = '0;
    bit         slaveBEn = 1'b1, slaveREn = 1'b1, strayB = 1'b0, strayR = 1'b0;

    // Slave internal state
    int awCnt = 0, wCnt = 0, arCnt = 0, holdCnt = 0;
    bit awSeen = 1'b0, wSeen = 1'b0, arSeen = 1'b0, bAcc = 1'b0, rAcc = 1'b0;

    // Monitor records
    int  cyc = 0;
    int  accCyc = -1, awValidFirst = -1, awHs = -1, wHs = -1, wValidLast = -1;
    int  arHs = -1, breadyFirst = -1, rHs = -1, rspValidFirst = -1, rspHs = -1;
    int  rspValidCnt = 0, bHsTotal = 0, rHsTotal = 0;
    int  busyReadyCnt = 0, stableErrs = 0, payloadErrs = 0, idleErrs = 0, protErrs = 0;
    bit  monActive = 1'b0, busy = 1'b0;
    logic [AW-1:0] curAddr = '0, lastAwAddr = '0, lastArAddr = '0;
    logic [DW-1:0] curData = '0, lastWData = '0, lastRspData = '0;
    logic [3:0]    curStrb = '0, lastWStrb = '0;
    logic          lastRspErr = 1'b0;

    // Free-running clock
    initial begin
        forever #5 i_clk = ~i_clk;
    end

    // Cycle counter advanced on every active edge
    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    // Run-away guard
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Slave reacts at the falling edge; monitor samples just after it
    initial begin
        forever begin
            @(negedge i_clk);
            if (!slaveBEn) begin
                M_AXI_BVALID = strayB;
                M_AXI_BRESP  = SLVERR;
            end else if (i_reset) begin
                M_AXI_BVALID = 1'b0;
                bAcc = 1'b0;
            end else begin
                if (bAcc) begin M_AXI_BVALID = 1'b0; bAcc = 1'b0; end
                if (awSeen && wSeen && !M_AXI_BVALID) begin
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = bResp; awSeen = 1'b0; wSeen = 1'b0;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) bAcc = 1'b1;
            end
            if (!slaveREn) begin
                M_AXI_RVALID = strayR;
                M_AXI_RRESP  = SLVERR;
            end else if (i_reset) begin
                M_AXI_RVALID = 1'b0;
                rAcc = 1'b0;
            end else begin
                if (rAcc) begin M_AXI_RVALID = 1'b0; rAcc = 1'b0; end
                if (arSeen && !M_AXI_RVALID) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RRESP = rResp; M_AXI_RDATA = rData; arSeen = 1'b0;
                end
                if (M_AXI_RVALID && M_AXI_RREADY) rAcc = 1'b1;
            end
            if (i_reset) begin
                M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0; i_rsp_ready = 1'b0;
                awCnt = 0; wCnt = 0; arCnt = 0; holdCnt = 0;
                awSeen = 1'b0; wSeen = 1'b0; arSeen = 1'b0;
            end else begin
                M_AXI_AWREADY = 1'b0;
                if (M_AXI_AWVALID) begin
                    if (awCnt >= awDelay) begin M_AXI_AWREADY = 1'b1; awSeen = 1'b1; awCnt = 0; end
                    else awCnt++;
                end
                M_AXI_WREADY = 1'b0;
                if (M_AXI_WVALID) begin
                    if (wCnt >= wDelay) begin M_AXI_WREADY = 1'b1; wSeen = 1'b1; wCnt = 0; end
                    else wCnt++;
                end
                M_AXI_ARREADY = 1'b0;
                if (M_AXI_ARVALID) begin
                    if (arCnt >= arDelay) begin M_AXI_ARREADY = 1'b1; arSeen = 1'b1; arCnt = 0; end
                    else arCnt++;
                end
                i_rsp_ready = 1'b0;
                if (o_rsp_valid) begin
                    if (holdCnt >= rspHold) begin i_rsp_ready = 1'b1; holdCnt = 0; end
                    else holdCnt++;
                end
            end

            #1;
            if (monActive && !i_reset) begin
                if (i_cmd_valid && o_cmd_ready) begin
                    accCyc = cyc; awValidFirst = -1; awHs = -1; wHs = -1; wValidLast = -1;
                    arHs = -1; breadyFirst = -1; rHs = -1; rspValidFirst = -1; rspHs = -1;
                    rspValidCnt = 0; busy = 1'b1;
                end else if (busy && o_cmd_ready) begin
                    busyReadyCnt++;
                end
                if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) protErrs++;
                if (M_AXI_AWVALID) begin
                    if (awValidFirst < 0) awValidFirst = cyc;
                    if (M_AXI_AWADDR !== curAddr) payloadErrs++;
                    if (M_AXI_AWREADY) awHs = cyc;
                    lastAwAddr = M_AXI_AWADDR;
                end else begin
`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
                    if (M_AXI_AWADDR !== '0) idleErrs++;
`else
                    if (M_AXI_AWADDR !== lastAwAddr) idleErrs++;
`endif
                end
                if (M_AXI_WVALID) begin
                    wValidLast = cyc;
                    if (M_AXI_WDATA !== curData || M_AXI_WSTRB !== curStrb) payloadErrs++;
                    if (M_AXI_WREADY) wHs = cyc;
                    lastWData = M_AXI_WDATA; lastWStrb = M_AXI_WSTRB;
                end else begin
`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
                    if (M_AXI_WDATA !== '0 || M_AXI_WSTRB !== '0) idleErrs++;
`else
                    if (M_AXI_WDATA !== lastWData || M_AXI_WSTRB !== lastWStrb) idleErrs++;
`endif
                end
                if (M_AXI_ARVALID) begin
                    if (M_AXI_ARADDR !== curAddr) payloadErrs++;
                    if (M_AXI_ARREADY) arHs = cyc;
                    lastArAddr = M_AXI_ARADDR;
                end else begin
`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
                    if (M_AXI_ARADDR !== '0) idleErrs++;
`else
                    if (M_AXI_ARADDR !== lastArAddr) idleErrs++;
`endif
                end
                if (M_AXI_BREADY && breadyFirst < 0) breadyFirst = cyc;
                if (M_AXI_BVALID && M_AXI_BREADY) begin bHsTotal++; end
                if (M_AXI_RVALID && M_AXI_RREADY) begin rHsTotal++; rHs = cyc; end
                if (o_rsp_valid) begin
                    rspValidCnt++;
                    if (rspValidFirst < 0) rspValidFirst = cyc;
                    if (expQ.size() > 0 && {o_rsp_data, o_rsp_err} !== expQ[0]) stableErrs++;
                    lastRspData = o_rsp_data; lastRspErr = o_rsp_err;
                    if (i_rsp_ready) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected response", 1, 0);
                        end else begin
                            rsp_t e;
                            e = expQ.pop_front();
                            checkOutput("rsp data", o_rsp_data, e.data);
                            checkOutput("rsp err", o_rsp_err, e.err);
                        end
                        rspHs = cyc;
                        busy = 1'b0;
                    end
                end else begin
`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
                    if (o_rsp_data !== '0 || o_rsp_err !== 1'b0) idleErrs++;
`else
                    if (o_rsp_data !== lastRspData || o_rsp_err !== lastRspErr) idleErrs++;
`endif
                end
            end
        end
    end

    task automatic doReset();
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        tick();
        i_reset = 1'b0;
        expQ.delete();
        busy = 1'b0;
        lastAwAddr = '0; lastArAddr = '0; lastWData = '0; lastWStrb = '0;
        lastRspData = '0; lastRspErr = 1'b0;
    endtask

    // Issue one command and push the response the slave configuration implies
    task automatic applyStimulus(input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [3:0] strb);
        int n = 0;
        rsp_t e;
        while (!o_cmd_ready && n < 200) begin tick(); n++; end
        if (!o_cmd_ready) begin
            checkOutput("cmd_ready timeout", 0, 1);
            return;
        end
        curAddr = addr; curData = data; curStrb = strb;
        e.data = we ? '0 : rData;
        e.err  = we ? (bResp != OKAY) : (rResp != OKAY);
        expQ.push_back(e);
        i_cmd_we = we; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 100) begin tick(); n++; end
        if (busy || expQ.size() != 0) begin
            checkOutput("response timeout", 0, 1);
            expQ.delete();
            busy = 1'b0;
        end
    endtask

    initial begin
        int a0, bBefore, rBefore, n;

        // Power-on reset
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        monActive = 1'b1;
        checkOutput("reset cmd_ready", o_cmd_ready, 1);
        checkOutput("reset valids/readies",
                    {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, o_rsp_valid, o_rsp_err}, 0);
        checkOutput("reset rsp_data", o_rsp_data, 0);

        // Zero-wait write
        awDelay = 0; wDelay = 0; bResp = OKAY; rspHold = 0;
        applyStimulus(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        waitDone();
        checkOutput("wr0 aw valid cycle", awValidFirst - accCyc, 1);
        checkOutput("wr0 aw handshake cycle", awHs - accCyc, 1);
        checkOutput("wr0 w handshake cycle", wHs - accCyc, 1);
        checkOutput("wr0 bready cycle", breadyFirst - accCyc, 2);
        checkOutput("wr0 rsp_valid cycle", rspValidFirst - accCyc, 3);

        // W accepted two cycles before AW
        awDelay = 2; wDelay = 0; bResp = OKAY;
        bBefore = bHsTotal;
        applyStimulus(1'b1, 4'h8, 32'hA5A50001, 4'h3);
        waitDone();
        checkOutput("wr1 w handshake cycle", wHs - accCyc, 1);
        checkOutput("wr1 w valid last cycle", wValidLast - accCyc, 1);
        checkOutput("wr1 aw handshake cycle", awHs - accCyc, 3);
        checkOutput("wr1 bready cycle", breadyFirst - accCyc, 4);
        repeat (3) tick();
        checkOutput("wr1 b beats", bHsTotal - bBefore, 1);

        // AW accepted first, error response
        awDelay = 0; wDelay = 3; bResp = DECERR;
        applyStimulus(1'b1, 4'h0, 32'h0BADF00D, 4'h8);
        waitDone();
        checkOutput("wr2 aw handshake cycle", awHs - accCyc, 1);
        checkOutput("wr2 w handshake cycle", wHs - accCyc, 4);
        checkOutput("wr2 bready cycle", breadyFirst - accCyc, 5);

        // Read with slave error and a stalled response port
        awDelay = 0; wDelay = 0; arDelay = 0;
        rData = 32'h12345678; rResp = SLVERR; rspHold = 3;
        applyStimulus(1'b0, 4'hC, 32'h0, 4'h0);
        waitDone();
        checkOutput("rd0 ar handshake cycle", arHs - accCyc, 1);
        checkOutput("rd0 r handshake cycle", rHs - accCyc, 2);
        checkOutput("rd0 rsp_valid cycle", rspValidFirst - accCyc, 3);
        checkOutput("rd0 rsp held cycles", rspValidCnt, 4);
        checkOutput("rd0 rsp handshake cycle", rspHs - accCyc, 6);

        // Back-to-back commands with a zero-wait slave
        rspHold = 0; bResp = OKAY; rResp = OKAY; rData = 32'hCAFE0001;
        applyStimulus(1'b1, 4'h2, 32'h11112222, 4'h5);
        a0 = accCyc;
        applyStimulus(1'b0, 4'h6, 32'h0, 4'h0);
        checkOutput("cmd period", accCyc - a0, 4);
        waitDone();

        // Reset while waiting for B, then a stray B beat
        slaveBEn = 1'b0; strayB = 1'b0;
        applyStimulus(1'b1, 4'hA, 32'h55AA55AA, 4'hF);
        n = 0;
        while (!M_AXI_BREADY && n < 20) begin tick(); n++; end
        checkOutput("reached WRESP", M_AXI_BREADY, 1);
        bBefore = bHsTotal;
        doReset();
        checkOutput("post-reset cmd_ready", o_cmd_ready, 1);
        checkOutput("post-reset bready/rsp", {M_AXI_BREADY, o_rsp_valid, o_rsp_err}, 0);
        checkOutput("post-reset rsp_data", o_rsp_data, 0);
        strayB = 1'b1;
        tick();
        checkOutput("stray B bvalid/bready", {M_AXI_BVALID, M_AXI_BREADY}, 2'b10);
        strayB = 1'b0;
        tick();
        tick();
        checkOutput("stray B state", {o_cmd_ready, o_rsp_valid, M_AXI_BREADY}, 3'b100);
        checkOutput("stray B no beat", bHsTotal - bBefore, 0);
        slaveBEn = 1'b1;

        // Stray R beat while idle
        slaveREn = 1'b0; strayR = 1'b1;
        rBefore = rHsTotal;
        tick();
        checkOutput("stray R rvalid/rready", {M_AXI_RVALID, M_AXI_RREADY}, 2'b10);
        strayR = 1'b0;
        tick();
        tick();
        checkOutput("stray R state", {o_cmd_ready, o_rsp_valid, M_AXI_RREADY}, 3'b100);
        checkOutput("stray R no beat", rHsTotal - rBefore, 0);
        slaveREn = 1'b1;
        tick();

        // Randomised traffic through the scoreboard
        for (int i = 0; i < 10; i++) begin
            bit we;
            we = 1'($urandom_range(0, 1));
            awDelay = $urandom_range(0, 3);
            wDelay  = $urandom_range(0, 3);
            arDelay = $urandom_range(0, 3);
            rspHold = $urandom_range(0, 2);
            bResp   = 2'($urandom_range(0, 3));
            rResp   = 2'($urandom_range(0, 3));
            rData   = $urandom;
            applyStimulus(we, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            waitDone();
        end

        checkOutput("payload while valid", payloadErrs, 0);
        checkOutput("payload while idle", idleErrs, 0);
        checkOutput("rsp stable while valid", stableErrs, 0);
        checkOutput("cmd_ready while busy", busyReadyCnt, 0);
        checkOutput("prot fields", protErrs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_single_master.md
AXIL_SINGLE_MASTER -- requirements
Module: axil_single_master

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 4, meaning AXI-lite address width in bits.
REQ-002 SHALL have parameter C_AXI_DATA_WIDTH, default 32, meaning AXI-lite data width in bits; only 32 is supported.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock; i_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have command ports: i_cmd_valid in 1; o_cmd_ready out 1; i_cmd_we in 1 (1=write); i_cmd_addr in C_AXI_ADDR_WIDTH; i_cmd_data in 32; i_cmd_strb in 4.
REQ-005 SHALL have response ports: o_rsp_valid out 1; i_rsp_ready in 1; o_rsp_data out 32 (read data, 0 for writes); o_rsp_err out 1 (xRESP != OKAY).
REQ-006 SHALL have AXI-lite master ports M_AXI_AW{VALID,READY,ADDR,PROT}, M_AXI_W{VALID,READY,DATA,STRB}, M_AXI_B{VALID,READY,RESP}, M_AXI_AR{VALID,READY,ADDR,PROT}, M_AXI_R{VALID,READY,DATA,RESP}, with AXI-lite widths and directions.

Function
REQ-007 SHALL use states IDLE, WRITE, WRESP, READ, RRESP, RETURN.
REQ-008 o_cmd_ready SHALL be 1 only in IDLE; a command is accepted on i_cmd_valid && o_cmd_ready.
REQ-009 On an accepted write: next cycle AWVALID=WVALID=1 with registered addr/data/strb; state WRITE.
REQ-010 In WRITE: AWVALID drops the cycle after AWREADY, WVALID the cycle after WREADY, independently and in either order; AW/W payloads stable while valid.
REQ-011 Once both AW and W have handshaken (including the same cycle), state WRESP with BREADY=1; BREADY SHALL be 0 in every other state.
REQ-012 On an accepted read: next cycle ARVALID=1; ARVALID drops the cycle after ARREADY; state RRESP with RREADY=1; RREADY SHALL be 0 in every other state.
REQ-013 On B or R handshake: capture RDATA (reads) or 0 (writes) and err = (resp != 2'b00); next cycle o_rsp_valid=1, state RETURN.
REQ-014 In RETURN: o_rsp_* SHALL stay stable until i_rsp_ready; on handshake return to IDLE; o_cmd_ready rises the following cycle.
REQ-015 At most one AXI transaction outstanding; minimum command-to-command period 4 cycles with zero-wait slave and i_rsp_ready=1.
REQ-016 AWPROT and ARPROT SHALL be 3'b000.
REQ-017 BVALID or RVALID arriving in a state not expecting it SHALL be ignored (READY low); no state change.

Reset
REQ-018 On i_reset: state IDLE; o_cmd_ready=1 the following cycle; all M_AXI_*VALID, BREADY, RREADY, o_rsp_valid, o_rsp_err = 0; o_rsp_data = 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction immediately; any subsequent B/R beat is ignored per REQ-017.

Configuration
REQ-020 Macro AXIL_SINGLE_MASTER_LOWPOWER_EN: when defined, AWADDR, WDATA, WSTRB, ARADDR SHALL be 0 whenever their VALID is 0, and o_rsp_data/o_rsp_err SHALL be 0 whenever o_rsp_valid is 0.
REQ-021 Without the macro, those payloads SHALL hold their last value when not valid; handshake timing SHALL be identical in both builds.

Structure
REQ-022 Package axil_single_master_pkg SHALL hold the state enum and constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
REQ-023 No sub-module; a single module, with AW and W valid flags as separate registers.

Verification
REQ-024 Write addr 4'h4, data 32'hDEADBEEF, strb 4'hF, AWREADY=WREADY=1, BRESP=OKAY -> AW/W valid cycle 1, BREADY cycle 2, o_rsp_valid cycle 3, err=0, data=0.
REQ-025 Write with WREADY two cycles before AWREADY -> WVALID drops first, AWVALID held with addr stable, exactly one B accepted.
REQ-026 Read addr 4'hC, RDATA 32'h12345678, RRESP=SLVERR, i_rsp_ready=0 for 3 cycles -> o_rsp_data=32'h12345678, err=1, held stable 4 cycles, o_cmd_ready=0 throughout.
REQ-027 Reset asserted in WRESP, stray BVALID one cycle after reset -> BREADY=0, o_rsp_valid=0, o_cmd_ready=1.
REQ-028 Idle with LOWPOWER_EN, then one read -> all M_AXI payloads and o_rsp_data 0 whenever the matching VALID is low; compare handshake timing with a non-LOWPOWER build cycle for cycle.
